// File: rtl/seg_bcd_counter_mux.sv
// Multi-digit BCD up/down counter with prescaled tick, load/pause/wrap, and a
// time-multiplexed common-anode 7-segment driver with leading-zero blanking.
module seg_bcd_counter_mux #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 25000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [SW-1:0]         scan;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic [4*DIGITS-1:0]   load_fix;
    logic [4*DIGITS-1:0]   count_inc;
    logic [4*DIGITS-1:0]   count_dec;
    logic                  carry;
    logic                  borrow;
    logic [3:0]            cur;
    logic                  upper_nz;
    logic                  blank;
    logic [7:0]            seg_next;
    logic [DIGITS-1:0]     an_next;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 8'b0000_0011;
            4'd1:    seg_decode = 8'b1001_1111;
            4'd2:    seg_decode = 8'b0010_0101;
            4'd3:    seg_decode = 8'b0000_1101;
            4'd4:    seg_decode = 8'b1001_1001;
            4'd5:    seg_decode = 8'b0100_1001;
            4'd6:    seg_decode = 8'b0100_0001;
            4'd7:    seg_decode = 8'b0001_1111;
            4'd8:    seg_decode = 8'b0000_0001;
            4'd9:    seg_decode = 8'b0000_1001;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    assign tick = en && (presc == PRESC_MAX);

    // Ripple carry/borrow that survives every digit means all-nines / all-zeros,
    // which is exactly the wrap condition for the respective direction.
    always_comb begin
        load_fix  = load_val;
        count_inc = count;
        count_dec = count;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9)
                load_fix[4*i +: 4] = 4'd9;
            if (carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            presc <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_fix;
            presc <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en)
                presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                count <= up_dn ? count_inc : count_dec;
                wrap  <= up_dn ? carry : borrow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan <= '0;
            idx  <= '0;
        end else if (scan == SCAN_MAX) begin
            scan <= '0;
            idx  <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end else begin
            scan <= scan + SW'(1);
        end
    end

    always_comb begin
        cur      = count[4*idx +: 4];
        upper_nz = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (i >= 32'(idx) && count[4*i +: 4] != 4'd0)
                upper_nz = 1'b1;
        end
        blank    = blank_lz && (idx != '0) && !upper_nz;
        seg_next = blank ? 8'hFF : seg_decode(cur);
        an_next  = '1;
        if (!blank)
            an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= 8'hFF;
            an  <= '1;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_bcd_counter_mux.sv
// Directed, table-driven bench for seg_bcd_counter_mux (DIGITS=4, TICK_DIV=4,
// SCAN_DIV=2): counting, wrap, load priority, pause, blanking and decode.
module tb_seg_bcd_counter_mux;

    logic        clk = 1'b0;
    logic        reset, en, up_dn, load, blank_lz;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        wrap;
    logic [7:0]  seg;
    logic [3:0]  an;

    int total = 0;
    int bad   = 0;

    seg_bcd_counter_mux #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .blank_lz(blank_lz), .count(count), .wrap(wrap),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic [15:0] exp_count;
        logic [7:0]  exp_seg;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] target);
        for (int k = 0; k < 12; k++) begin
            step();
            if (an == target) break;
        end
        check("an_reach", {28'd0, an}, {28'd0, target});
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        step();
        load     = 1'b0;
    endtask

    initial begin
        int wrap_seen;
        int n_e, n_d, n_b, n_f;

        vecs[0]  = '{16'h0000, 16'h0000, 8'h03};
        vecs[1]  = '{16'h0001, 16'h0001, 8'h9F};
        vecs[2]  = '{16'h0002, 16'h0002, 8'h25};
        vecs[3]  = '{16'h0003, 16'h0003, 8'h0D};
        vecs[4]  = '{16'h0004, 16'h0004, 8'h99};
        vecs[5]  = '{16'h0005, 16'h0005, 8'h49};
        vecs[6]  = '{16'h0006, 16'h0006, 8'h41};
        vecs[7]  = '{16'h0007, 16'h0007, 8'h1F};
        vecs[8]  = '{16'h0008, 16'h0008, 8'h01};
        vecs[9]  = '{16'h0009, 16'h0009, 8'h09};
        vecs[10] = '{16'h000F, 16'h0009, 8'h09};
        vecs[11] = '{16'h12A4, 16'h1294, 8'h99};
        vecs[12] = '{16'hFFFF, 16'h9999, 8'h09};
        vecs[13] = '{16'h0B07, 16'h0907, 8'h1F};

        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_val = '0; blank_lz = 1'b0;
        step();
        check("rst_count", {16'd0, count}, 32'h0);
        check("rst_seg",   {24'd0, seg},   32'hFF);
        check("rst_an",    {28'd0, an},    32'hF);
        check("rst_wrap",  {31'd0, wrap},  32'h0);

        // Free-running up count: one increment every 4 edges.
        reset = 1'b0; en = 1'b1; up_dn = 1'b1;
        wrap_seen = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (wrap) wrap_seen++;
            if (k == 39) check("up_39", {16'd0, count}, 32'h0009);
        end
        check("up_40",      {16'd0, count}, 32'h0010);
        check("up_nowrap",  wrap_seen, 0);
        step(); step();
        reset = 1'b1; load = 1'b1; load_val = 16'h1234;
        step();
        check("midrst_count", {16'd0, count}, 32'h0);
        check("midrst_seg",   {24'd0, seg},   32'hFF);
        check("midrst_an",    {28'd0, an},    32'hF);
        reset = 1'b0; load = 1'b0;

        // Up wrap from 9999, then down wrap from 0000.
        en = 1'b1; up_dn = 1'b1;
        do_load(16'h9998);
        repeat (3) step();
        check("w_9998", {16'd0, count}, 32'h9998);
        step();
        check("w_9999",   {16'd0, count}, 32'h9999);
        check("w_9999_w", {31'd0, wrap},  32'h0);
        repeat (3) step();
        check("w_hold",   {16'd0, count}, 32'h9999);
        step();
        check("w_0000",   {16'd0, count}, 32'h0000);
        check("w_up_wrap",{31'd0, wrap},  32'h1);
        up_dn = 1'b0;
        step();
        check("w_pulse1", {31'd0, wrap},  32'h0);
        check("w_dir_wait", {16'd0, count}, 32'h0000);
        step(); step();
        check("w_dn_hold", {16'd0, count}, 32'h0000);
        step();
        check("w_dn_9999", {16'd0, count}, 32'h9999);
        check("w_dn_wrap", {31'd0, wrap},  32'h1);
        step();
        check("w_dn_pulse1", {31'd0, wrap}, 32'h0);

        // Load in the tick cycle that would otherwise wrap.
        up_dn = 1'b1;
        do_load(16'h9999);
        repeat (3) step();
        load = 1'b1; load_val = 16'h0500;
        step();
        load = 1'b0;
        check("ld_tick_count", {16'd0, count}, 32'h0500);
        check("ld_tick_wrap",  {31'd0, wrap},  32'h0);
        repeat (3) step();
        check("ld_presc_clr", {16'd0, count}, 32'h0500);
        step();
        check("ld_next_tick", {16'd0, count}, 32'h0501);

        // Pause mid-prescale; resume from the held prescaler value.
        do_load(16'h0000);
        step(); step();
        en = 1'b0;
        repeat (10) step();
        check("pause_hold", {16'd0, count}, 32'h0000);
        en = 1'b1;
        step();
        check("resume_1", {16'd0, count}, 32'h0000);
        step();
        check("resume_2", {16'd0, count}, 32'h0001);
        en = 1'b0;

        // Decode sweep and load clamping, observed on digit 0.
        for (int v = 0; v < 14; v++) begin
            do_load(vecs[v].val);
            check("tbl_count", {16'd0, count}, {16'd0, vecs[v].exp_count});
            wait_an(4'hE);
            check("tbl_seg", {24'd0, seg}, {24'd0, vecs[v].exp_seg});
        end

        // Leading-zero blanking over 8 scan slots.
        blank_lz = 1'b1;
        do_load(16'h0305);
        step();
        n_e = 0; n_d = 0; n_b = 0; n_f = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            case (an)
                4'hE: begin n_e++; check("lz_seg_d0", {24'd0, seg}, 32'h49); end
                4'hD: begin n_d++; check("lz_seg_d1", {24'd0, seg}, 32'h03); end
                4'hB: begin n_b++; check("lz_seg_d2", {24'd0, seg}, 32'h0D); end
                4'hF: begin n_f++; check("lz_seg_d3", {24'd0, seg}, 32'hFF); end
                default: check("lz_an_valid", {28'd0, an}, 32'hE);
            endcase
        end
        check("lz_cnt_e", n_e, 4);
        check("lz_cnt_d", n_d, 4);
        check("lz_cnt_b", n_b, 4);
        check("lz_cnt_f", n_f, 4);
        blank_lz = 1'b0;
        wait_an(4'h7);
        check("nolz_seg_d3", {24'd0, seg}, 32'h03);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_bcd_counter_mux.md
Name: seg_bcd_counter_mux

Overview:
- Parametrised multi-digit BCD up/down counter that drives a time-multiplexed, common-anode 7-segment display.
- An internal prescaler generates the count tick, and a scan divider rotates the active digit.
- Adds load, pause, count direction, wrap pulse and leading-zero blanking.
- Sits between the board clock/switches and the display pins; it is the display/counting building block for lab designs.

Parameters:
- DIGITS, 4, number of BCD digits and anode lines (1..8).
- TICK_DIV, 25000000, clk cycles per count tick (>=2).
- SCAN_DIV, 50000, clk cycles each digit stays active during scan (>=1).

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- en, input, 1, count enable; prescaler frozen while low.
- up_dn, input, 1, direction: 1 = up, 0 = down; sampled on the tick cycle.
- load, input, 1, synchronous load of load_val.
- load_val, input, 4*DIGITS, BCD load value; digit i is bits [4i+3:4i].
- blank_lz, input, 1, 1 = blank leading zeros.
- count, output, 4*DIGITS, current BCD count, registered.
- wrap, output, 1, one-cycle pulse when the count wraps.
- seg, output, 8, active-low segments {a,b,c,d,e,f,g,dp}, registered.
- an, output, DIGITS, active-low anode enables, registered; at most one bit is low.

Behaviour:
- Reset (synchronous, active-high, clock clk): count=0, prescaler=0, scan counter=0, digit index=0, wrap=0, seg=8'hFF, an=all ones. Reset has priority over every other input, including mid-tick or mid-load.
- Prescaler: while en=1 it counts 0..TICK_DIV-1 and returns to 0. The tick is asserted in the cycle the prescaler equals TICK_DIV-1. While en=0 the prescaler holds its value and no tick occurs.
- Priority of count updates: reset > load > tick.
- load=1: count <= load_val and prescaler <= 0 on the same edge; any tick in that cycle is discarded and wrap=0. Any loaded digit greater than 9 is stored as 9.
- Tick, up: the count increments as a decimal ripple (digit 9 -> 0 with carry into the next digit). From all-nines it goes to all-zeros and wrap=1 for exactly that cycle.
- Tick, down: the count decrements as a decimal ripple (digit 0 -> 9 with borrow). From all-zeros it goes to all-nines and wrap=1 for exactly that cycle.
- Count update latency: count changes on the clock edge that ends the tick cycle. wrap is registered and is high in the cycle after that edge, aligned with the new count.
- Scan counter: counts 0..SCAN_DIV-1 unconditionally, regardless of en. On wrap it advances the index i -> (i+1) mod DIGITS; index 0 is the least significant digit.
- Display outputs: seg and an are registered from the index and the current count, giving 1 cycle of latency after an index or count change.
- an: bit i is 0 for the active index; all other bits are 1.
- Segment decode (dp is always off, so bit0=1):
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001
  - 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001
- Leading-zero blanking: when blank_lz=1 and i>0, digit i is blanked if it and all higher digits are 0. A blanked digit outputs seg=8'hFF and its an bit is 1. Digit 0 is never blanked.
- Simultaneous events: load together with en=0 still loads. A direction change takes effect only on the next tick. A count change mid-scan updates the displayed digit after 1 cycle.
- DIGITS=1 degenerate case: the index stays at 0 and an is tied low after reset.

Test Plan (DIGITS=4, TICK_DIV=4, SCAN_DIV=2 unless noted):
1. Reset, then en=1, up_dn=1 for 40 cycles -> count steps by 1 every 4 cycles, reaching 0x0010 after 10 ticks; wrap stays 0. Assert reset mid-run -> count=0, seg=FF, an=F on the next edge.
2. load 0x9998, then en=1, up -> count goes 9999 then 0000; wrap=1 for one cycle aligned with 0000. Next, down from 0000 -> 9999 with wrap=1.
3. load 0x12A4 -> count=0x1294 and prescaler cleared. Assert load in the same cycle as a tick -> the loaded value wins and wrap=0.
4. en toggled 0 for 10 cycles mid-prescale -> the count and prescaler hold, then resume from the held prescaler value (the next tick lands exactly where it would have without the pause).
5. count=0x0305, blank_lz=1, observe 8 scan slots -> the an sequence is E,D,B,(blank) with seg 49,03,0D,FF. With blank_lz=0, digit 3 shows 03 with an=7.
6. Decode sweep: load each value 0..9 into digit 0 -> seg matches the table exactly, and bit0 is always 1.
